// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory master: access sizes, FSM states,
// data width and the alignment rule.
package dmem_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RSP  = 2'b11
    } state_e;

    // Expects a normalised size (reserved 2'b11 already folded to SIZE_W).
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_H:  bad = lo[0];
            SIZE_W:  bad = (lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane logic: extracts and extends a loaded lane, and merges
// store data into a word read from memory.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              sext,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged_word
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted     = rd_word >> {lane, 3'b000};
        load_data   = shifted;
        merged_word = wr_data;
        case (size)
            SIZE_B: begin
                load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
                merged_word = rd_word;
                merged_word[{lane, 3'b000} +: 8] = wr_data[7:0];
            end
            SIZE_H: begin
                load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
                merged_word = rd_word;
                merged_word[{lane[1], 4'b0000} +: 16] = wr_data[15:0];
            end
            default: begin
                load_data   = rd_word;
                merged_word = wr_data;
            end
        endcase
    end

endmodule

// File: rtl/dmem_master.sv
// CPU-side load/store master for a single-port, combinational-read data memory.
// Sub-word stores are done as a read-modify-write with a single full-word write.
module dmem_master
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [31:0]       dmem_addr,
    output logic [DATA_W-1:0] dmem_wr_data,
    input  logic [DATA_W-1:0] dmem_rd_data,
    output state_e            state
);

    // Handshakes: a request transfers when req_valid && req_ready at a rising
    // clk edge; a response transfers when rsp_valid && rsp_ready at a rising
    // edge, and rsp_valid/rsp_data/rsp_err hold until then.

    state_e            state_q, state_d;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wr_word_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic [1:0]        size_norm;
    logic              req_bad;
    logic              accept;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged_word;

    assign size_norm = (req_size == 2'b11) ? SIZE_W : req_size;
    assign req_bad   = misaligned(size_norm, req_addr[1:0]);
    assign accept    = req_valid && req_ready;
    assign state     = state_q;

    dmem_lane_align u_lane_align (
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .sext        (signed_q),
        .rd_word     (dmem_rd_data),
        .wr_data     (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_addr    = '0;
        dmem_wr_data = '0;
        rsp_data     = '0;
        rsp_err      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = RSP;
                    end else if (req_write && size_norm == SIZE_W) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                dmem_read = 1'b1;
                dmem_addr = {2'b00, addr_q[31:2]};
                state_d   = write_q ? WR : RSP;
            end
            WR: begin
                dmem_write   = 1'b1;
                dmem_addr    = {2'b00, addr_q[31:2]};
                dmem_wr_data = wr_word_q;
                state_d      = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = rsp_data_q;
                rsp_err   = rsp_err_q;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word stores take their write word straight from the request; sub-word
    // stores overwrite it with the merged word at the end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            size_q     <= SIZE_W;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_word_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            write_q    <= req_write;
            size_q     <= size_norm;
            signed_q   <= req_signed;
            addr_q     <= req_addr;
            wdata_q    <= req_wr_data;
            wr_word_q  <= req_wr_data;
            rsp_data_q <= '0;
            rsp_err_q  <= req_bad;
        end else if (state_q == RD) begin
            if (write_q) begin
                wr_word_q <= merged_word;
            end else begin
                rsp_data_q <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master: a bench-side memory, a byte-level reference
// model, per-transaction checks and a per-cycle invariant monitor.
module tb_dmem_master;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wr_data;
    logic [31:0] dmem_rd_data;
    state_e      dut_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit mon_en = 1'b0;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic        mem_clr = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    always #5 clk = ~clk;

    dmem_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wr_data  (req_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
        .dmem_rd_data (dmem_rd_data),
        .state        (dut_state)
    );

    // DataMemory stand-in: combinational read, write on the clock.
    assign dmem_rd_data = mem[dmem_addr[3:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (dmem_write) begin
            mem[dmem_addr[3:0]] <= dmem_wr_data;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(posedge clk);
        #1;
        pl_en  = 1'b1;
        pl_idx = idx[3:0];
        pl_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Reference model: byte-wise view of memory and the access rules.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] e_data, output logic e_err,
                         output int e_lat, output int e_rd, output int e_wr,
                         output logic [31:0] e_word);
        int nb;
        int off;
        int idx;
        logic [31:0] word;
        logic [31:0] mask;
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off  = int'(a[1:0]);
        idx  = int'(a[5:2]);
        word = ref_mem[idx];
        e_data = '0; e_err = 1'b0; e_rd = 0; e_wr = 0; e_word = '0; e_lat = 1;
        if ((a % nb) != 0) begin
            e_err = 1'b1;
        end else if (!w) begin
            e_lat = 2;
            e_rd  = 1;
            e_data = word >> (8 * off);
            if (nb < 4) begin
                mask = (32'd1 << (8 * nb)) - 32'd1;
                e_data = e_data & mask;
                if (sg && e_data[8 * nb - 1]) e_data = e_data | ~mask;
            end
        end else begin
            for (int i = 0; i < nb; i++) word[8 * (off + i) +: 8] = wd[8 * i +: 8];
            ref_mem[idx] = word;
            e_word = word;
            e_wr   = 1;
            e_rd   = (nb < 4) ? 1 : 0;
            e_lat  = (nb < 4) ? 3 : 2;
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int hold,
                          input bit pin_en, input logic [31:0] pin_val);
        logic [31:0] e_data, e_word, held;
        logic e_err;
        int e_lat, e_rd, e_wr, rd_n, wr_n, rd_c, wr_c, lat;
        bit ok;
        model(w, sz, sg, a, wd, e_data, e_err, e_lat, e_rd, e_wr, e_word);
        if (pin_en) check("model_pin", w ? e_word : e_data, pin_val);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wr_data = wd;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rd_n = 0; wr_n = 0; rd_c = 0; wr_c = 0; lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (dmem_read) begin rd_n++; rd_c = c; end
            if (dmem_write) begin
                wr_n++; wr_c = c;
                check("wr_data", dmem_wr_data, e_word);
            end
            if (dmem_read || dmem_write) check("dmem_addr", dmem_addr, {2'b00, a[31:2]});
            if (rsp_valid) lat = c;
        end
        check("rsp_latency", lat, e_lat);
        check("read_pulses", rd_n, e_rd);
        check("write_pulses", wr_n, e_wr);
        if (rd_n == 1 && wr_n == 1) check("read_before_write", rd_c < wr_c, 1);
        check("rsp_data", rsp_data, e_data);
        check("rsp_err", rsp_err, e_err);
        held = rsp_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_data_stable", rsp_data, held);
            check("bp_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_after_rsp", {rsp_valid, req_ready}, 2'b01);
    endtask

    // Per-cycle invariants on the memory-side strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_exclusive", dmem_read && dmem_write, 0);
            check("ready_only_idle", req_ready, dut_state == IDLE);
            if (req_ready) check("idle_quiet", {dmem_read, dmem_write, dmem_addr}, 0);
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        check("reset_outputs", {dmem_read, dmem_write, rsp_valid, rsp_err}, 0);
        check("reset_addr", dmem_addr, 0);
        check("reset_wr_data", dmem_wr_data, 0);
        check("reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        preload(2, 32'h11223344);
        do_req(1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, 0, 1'b1, 32'h11223344);
        preload(1, 32'h80FF7F01);
        do_req(1'b0, SIZE_B, 1'b1, 32'h6, 32'h0, 0, 1'b1, 32'hFFFFFFFF);
        do_req(1'b0, SIZE_B, 1'b0, 32'h6, 32'h0, 0, 1'b1, 32'h000000FF);
        preload(0, 32'hAABBCCDD);
        do_req(1'b1, SIZE_B, 1'b0, 32'h1, 32'h55, 0, 1'b1, 32'hAABB55DD);
        do_req(1'b1, SIZE_H, 1'b0, 32'h3, 32'h1234, 0, 1'b0, 32'h0);
        do_req(1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, 5, 1'b1, 32'h11223344);
        do_req(1'b1, SIZE_W, 1'b0, 32'hC, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF);
        do_req(1'b0, SIZE_W, 1'b0, 32'hC, 32'h0, 0, 1'b1, 32'hDEADBEEF);
        do_req(1'b1, SIZE_H, 1'b0, 32'h6, 32'h1234ABCD, 0, 1'b1, 32'hABCD7F01);
        do_req(1'b0, SIZE_H, 1'b1, 32'h6, 32'h0, 0, 1'b1, 32'hFFFFABCD);
        do_req(1'b0, SIZE_H, 1'b1, 32'h4, 32'h0, 0, 1'b1, 32'h00007F01);
        do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, 0, 1'b1, 32'h11223344);
        do_req(1'b0, 2'b11, 1'b0, 32'hA, 32'h0, 0, 1'b1, 32'h0);
        do_req(1'b0, SIZE_B, 1'b1, 32'h3, 32'h0, 2, 1'b1, 32'hFFFFFFAA);
        do_req(1'b0, SIZE_W, 1'b0, 32'h9, 32'h0, 0, 1'b1, 32'h0);
        do_req(1'b1, SIZE_B, 1'b0, 32'h22, 32'h9A, 1, 1'b1, 32'h009A0000);

        // Reset during the read phase of a byte store must abandon the write.
        preload(0, 32'hAABBCCDD);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_B; req_signed = 1'b0;
        req_addr = 32'h0; req_wr_data = 32'h12;
        @(negedge clk);
        check("rmw_rst_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rst_in_rd", dmem_read, 1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_strobes", {dmem_read, dmem_write, rsp_valid, rsp_err}, 0);
        check("rmw_rst_addr", dmem_addr, 0);
        check("rmw_rst_wr_data", dmem_wr_data, 0);
        @(posedge clk);
        #1;
        check("rmw_rst_held", {dmem_read, dmem_write, rsp_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rmw_rst_ready_after", req_ready, 1);
        check("rmw_rst_mem0", mem[0], 32'hAABBCCDD);

        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_master.md
DMEM_MASTER -- requirements
Module: dmem_master

Interface
REQ-001 Clk  input  1  single clock for all logic; DataMemory writes on the same clock.
REQ-002 Rst_n  input  1  reset, asynchronous, active-low.
REQ-003 ReqValid  input  1  CPU load/store request valid.
REQ-004 ReqReady  output  1  request accepted when ReqValid && ReqReady at a rising Clk edge.
REQ-005 ReqWrite  input  1  1 = store, 0 = load.
REQ-006 ReqSize  input  2  00 byte, 01 halfword, 10 word; 11 is reserved and treated as word.
REQ-007 ReqSigned  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-008 ReqAddr  input  32  byte address.
REQ-009 ReqWrData  input  32  store data, right-aligned.
REQ-010 RspValid  output  1  response valid; held until RspReady.
REQ-011 RspReady  input  1  CPU accepts the response.
REQ-012 RspData  output  32  load result, extended; 0 for stores and errors.
REQ-013 RspErr  output  1  misaligned access flag, qualified by RspValid.
REQ-014 DmemRead  output  1  read strobe to DataMemory.
REQ-015 DmemWrite  output  1  write strobe to DataMemory.
REQ-016 DmemAddr  output  32  word index, equal to {2'b00, addr[31:2]}.
REQ-017 DmemWrData  output  32  full word to write.
REQ-018 DmemRdData  input  32  combinational read data from DataMemory.

Function
REQ-019 The FSM states SHALL be IDLE, RD, WR and RSP.
REQ-020 ReqReady SHALL be 1 only in IDLE; the request fields SHALL be registered on acceptance.
REQ-021 Misaligned requests SHALL go IDLE->RSP with RspErr=1 and no Dmem strobe. A request is misaligned when the halfword address has addr[0]=1, or the word address has addr[1:0]!=0.
REQ-022 Loads SHALL follow IDLE->RD->RSP.
  - In RD: DmemRead=1 for exactly one cycle.
  - DmemRdData SHALL be captured at the end of RD.
  - RspValid SHALL assert 2 cycles after acceptance.
REQ-023 Word stores SHALL follow IDLE->WR->RSP.
  - In WR: DmemWrite=1 for exactly one cycle.
  - DmemWrData SHALL equal ReqWrData.
REQ-024 Byte and halfword stores SHALL be read-modify-write: IDLE->RD->WR->RSP.
  - Only the addressed lane(s) SHALL be replaced.
  - The other bytes of the word read in RD SHALL be preserved.
REQ-025 Lane selection SHALL follow little-endian order:
  - byte lane = addr[1:0];
  - halfword lane = addr[1].
REQ-026 Sub-word load extraction SHALL shift the addressed lane to bit 0, then sign- or zero-extend it per ReqSigned.
REQ-027 DmemRead and DmemWrite SHALL never be 1 in the same cycle, and both SHALL be 0 outside RD and WR.
REQ-028 DmemAddr SHALL be stable for the whole of RD and WR in one transaction, and 0 in IDLE.
REQ-029 In RSP, RspValid=1; on RspReady=1 the FSM SHALL return to IDLE, and a new request is accepted no earlier than the next cycle.
REQ-030 RspData and RspErr SHALL be held constant while RspValid=1 and RspReady=0.

Reset
REQ-031 On Rst_n=0, state SHALL go to IDLE immediately, regardless of the current state, including mid-RMW.
REQ-032 The following outputs SHALL be 0 during reset: DmemRead, DmemWrite, DmemAddr, DmemWrData, RspValid, RspData, RspErr.
REQ-033 ReqReady SHALL be 1 after reset release.
REQ-034 An RMW interrupted by reset SHALL leave memory either unwritten or fully written, never partially written.

Structure
REQ-035 The shared package dmem_pkg SHALL hold:
  - size encodings SIZE_B, SIZE_H, SIZE_W;
  - the FSM state encoding;
  - the data width constant (32).
REQ-036 Lane extract and merge logic SHALL be a combinational sub-module, dmem_lane_align, instantiated once.

Verification
REQ-037 Word load, mem[2]=0x11223344, ReqAddr=0x8: RspValid in cycle 2, RspData=0x11223344, one DmemRead pulse with DmemAddr=2.
REQ-038 Signed byte load, mem[1]=0x80FF7F01, ReqAddr=0x6, ReqSigned=1: RspData=0xFFFFFFFF. The same load with ReqSigned=0: RspData=0x000000FF.
REQ-039 Byte store, mem[0]=0xAABBCCDD, ReqAddr=0x1, ReqWrData=0x55:
  - one DmemRead pulse, then one DmemWrite pulse;
  - DmemWrData=0xAABB55DD;
  - RspValid in cycle 3.
REQ-040 Misaligned halfword, ReqAddr=0x3: RspErr=1 after 1 cycle, no DmemRead/DmemWrite, RspData=0.
REQ-041 Backpressure: hold RspReady=0 for 5 cycles after a load. RspData SHALL stay constant and ReqReady=0; on release, IDLE next cycle.
REQ-042 Reset asserted during RD of a byte store: strobes drop immediately, and mem[0] is unchanged after release.
